gfifo_fwft: RTL and testbench

//  Parametrised first-word-fall-through FIFO, next generation of the BFIFO/DFIFO pair.
//  One module covers both storage styles (MODE), adds almost-full/almost-empty thresholds,

---
 rtl/gfifo_fwft_pkg.sv | 21 ++
 rtl/gfifo_ram.sv | 55 +++++
 rtl/gfifo_fwft.sv | 159 +++++++++++++++
 tb/tb_gfifo_fwft.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gfifo_fwft_pkg.sv
// rtl/gfifo_fwft_pkg.sv - shared constants and helpers for the gfifo_fwft FIFO
// Purpose: storage-mode selectors and a constant log2 helper used to size address buses.
// Ports: none (package).
package gfifo_fwft_pkg;

    localparam int FIFO_MODE_DIST = 0;  // distributed RAM, combinational read
    localparam int FIFO_MODE_BRAM = 1;  // block RAM, registered read

    // Smallest r with (1 << r) >= value; constant-foldable for parameter use.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gfifo_ram.sv
// rtl/gfifo_ram.sv - simple dual-port storage array for gfifo_fwft
// Purpose: one write port, one read port; RD_REG selects combinational or registered read.
// Ports:
//   i_clk     clock
//   i_we      write enable
//   i_waddr   write address
//   i_wdata   write data
//   i_re      read enable (registered read only; holds o_rdata when low)
//   i_raddr   read address
//   o_rdata   read data
module gfifo_ram
    import gfifo_fwft_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 32,
    parameter bit RD_REG = 1'b0
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [clog2(DEPTH)-1:0]   i_waddr,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic                      i_re,
    input  logic [clog2(DEPTH)-1:0]   i_raddr,
    output logic [WIDTH-1:0]          o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately never reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    if (RD_REG) begin : g_reg_read
        // The read register doubles as the FIFO output stage, so it only
        // loads on a fetch and otherwise keeps the current head word stable.
        logic [WIDTH-1:0] r_rdata;

        always_ff @(posedge i_clk) begin
            if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end

        assign o_rdata = r_rdata;
    end else begin : g_comb_read
        logic w_unused_re;

        assign w_unused_re = i_re;
        assign o_rdata     = r_mem[i_raddr];
    end

endmodule

// File: rtl/gfifo_fwft.sv
// rtl/gfifo_fwft.sv - parametrised first-word-fall-through FIFO (distributed or block RAM)
// Purpose: FWFT FIFO with count, full/almost-full/almost-empty flags, sticky
//          overflow/underflow flags and a synchronous flush.
// Ports:
//   i_clk     clock
//   i_rst_x   asynchronous active-low reset
//   i_clr     synchronous flush (clears state and flags, keeps RAM contents)
//   i_enq     write request
//   i_deq     pop request, acknowledges the word at o_dot
//   i_din     write data
//   o_dot     head word, valid while !o_emp, zero while o_emp
//   o_emp     no valid head word at o_dot
//   o_full    o_cnt == DEPTH
//   o_afull   o_cnt >= AFULL_TH
//   o_aemp    o_cnt <= AEMP_TH
//   o_cnt     entries held, including the output stage in MODE 1
//   o_ovf     sticky: enq rejected because full
//   o_udf     sticky: deq seen while empty
module gfifo_fwft
    import gfifo_fwft_pkg::*;
#(
    parameter int FIFO_SIZE  = 4,
    parameter int FIFO_WIDTH = 32,
    parameter int MODE       = FIFO_MODE_DIST,
    parameter int AFULL_TH   = 12,
    parameter int AEMP_TH    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_x,
    input  logic                  i_clr,
    input  logic                  i_enq,
    input  logic                  i_deq,
    input  logic [FIFO_WIDTH-1:0] i_din,
    output logic [FIFO_WIDTH-1:0] o_dot,
    output logic                  o_emp,
    output logic                  o_full,
    output logic                  o_afull,
    output logic                  o_aemp,
    output logic [FIFO_SIZE:0]    o_cnt,
    output logic                  o_ovf,
    output logic                  o_udf
);

    localparam int LP_DEPTH = 1 << FIFO_SIZE;
    localparam int LP_AW    = clog2(LP_DEPTH);
    localparam int LP_CW    = FIFO_SIZE + 1;

    localparam logic [LP_CW-1:0] LP_DEPTH_C = LP_CW'(LP_DEPTH);
    localparam logic [LP_CW-1:0] LP_AFULL_C = LP_CW'(AFULL_TH);
    localparam logic [LP_CW-1:0] LP_AEMP_C  = LP_CW'(AEMP_TH);
    localparam logic [LP_CW-1:0] LP_ONE_C   = LP_CW'(1);
    localparam logic [LP_AW-1:0] LP_PTR_ONE = LP_AW'(1);

    logic [LP_AW-1:0]      r_head;
    logic [LP_AW-1:0]      r_tail;
    logic [LP_CW-1:0]      r_cnt;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_head_vld;
    logic                  w_full;
    logic                  w_deq_acc;
    logic                  w_enq_acc;
    logic                  w_ram_re;
    logic [FIFO_WIDTH-1:0] w_rdata;

    assign w_full    = (r_cnt == LP_DEPTH_C);
    assign w_deq_acc = i_deq && w_head_vld && !i_clr;
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign w_enq_acc = i_enq && !i_clr && (!w_full || w_deq_acc);

    if (MODE == FIFO_MODE_BRAM) begin : g_bram
        // r_ov marks a valid word in the RAM read register (the output stage).
        // Emptiness follows r_ov only: cnt already counts a word that is still
        // in flight through the registered read.
        logic             r_ov;
        logic [LP_CW-1:0] w_ram_cnt;

        assign w_ram_cnt  = r_cnt - {{FIFO_SIZE{1'b0}}, r_ov};
        // Refill the output stage whenever it is free or being popped this
        // cycle, giving back-to-back pops with no bubble.
        assign w_ram_re   = !i_clr && (w_ram_cnt != '0) && (!r_ov || w_deq_acc);
        assign w_head_vld = r_ov;

        always_ff @(posedge i_clk or negedge i_rst_x) begin
            if (!i_rst_x) begin
                r_ov <= 1'b0;
            end else if (i_clr) begin
                r_ov <= 1'b0;
            end else if (w_ram_re) begin
                r_ov <= 1'b1;
            end else if (w_deq_acc) begin
                r_ov <= 1'b0;
            end
        end
    end else begin : g_dist
        // The read pointer is the head itself; it advances on each pop.
        assign w_ram_re   = w_deq_acc;
        assign w_head_vld = (r_cnt != '0);
    end

    gfifo_ram #(
        .DEPTH  (LP_DEPTH),
        .WIDTH  (FIFO_WIDTH),
        .RD_REG (MODE == FIFO_MODE_BRAM)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_enq_acc),
        .i_waddr (r_tail),
        .i_wdata (i_din),
        .i_re    (w_ram_re),
        .i_raddr (r_head),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else if (i_clr) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            if (w_enq_acc) begin
                r_tail <= r_tail + LP_PTR_ONE;
            end
            if (w_ram_re) begin
                r_head <= r_head + LP_PTR_ONE;
            end
            case ({w_enq_acc, w_deq_acc})
                2'b10:   r_cnt <= r_cnt + LP_ONE_C;
                2'b01:   r_cnt <= r_cnt - LP_ONE_C;
                default: r_cnt <= r_cnt;
            endcase
            if (i_enq && !w_enq_acc) begin
                r_ovf <= 1'b1;
            end
            if (i_deq && !w_head_vld) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign o_dot   = w_head_vld ? w_rdata : '0;
    assign o_emp   = !w_head_vld;
    assign o_full  = w_full;
    assign o_afull = (r_cnt >= LP_AFULL_C);
    assign o_aemp  = (r_cnt <= LP_AEMP_C);
    assign o_cnt   = r_cnt;
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;

endmodule

// File: tb/tb_gfifo_fwft.sv
// tb/tb_gfifo_fwft.sv - self-checking bench for gfifo_fwft, both storage modes side by side
module tb_gfifo_fwft;

    logic        clk = 1'b0;
    logic        rst_x;
    logic        clr;
    logic        enq;
    logic        deq;
    logic [31:0] din;

    logic [31:0] dot   [2];
    logic        emp   [2];
    logic        full  [2];
    logic        afull [2];
    logic        aemp  [2];
    logic [4:0]  cnt   [2];
    logic        ovf   [2];
    logic        udf   [2];

    always #5 clk = ~clk;

    gfifo_fwft #(.FIFO_SIZE(4), .FIFO_WIDTH(32), .MODE(0), .AFULL_TH(12), .AEMP_TH(2)) u_dut0 (
        .i_clk(clk), .i_rst_x(rst_x), .i_clr(clr), .i_enq(enq), .i_deq(deq), .i_din(din),
        .o_dot(dot[0]), .o_emp(emp[0]), .o_full(full[0]), .o_afull(afull[0]),
        .o_aemp(aemp[0]), .o_cnt(cnt[0]), .o_ovf(ovf[0]), .o_udf(udf[0])
    );

    gfifo_fwft #(.FIFO_SIZE(4), .FIFO_WIDTH(32), .MODE(1), .AFULL_TH(12), .AEMP_TH(2)) u_dut1 (
        .i_clk(clk), .i_rst_x(rst_x), .i_clr(clr), .i_enq(enq), .i_deq(deq), .i_din(din),
        .o_dot(dot[1]), .o_emp(emp[1]), .o_full(full[1]), .o_afull(afull[1]),
        .o_aemp(aemp[1]), .o_cnt(cnt[1]), .o_ovf(ovf[1]), .o_udf(udf[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per mode a circular list of words with the cycle each
    // was enqueued. A word is visible at the head from max(enq cycle + latency,
    // cycle after the previous word left), latency 1 for MODE 0, 2 for MODE 1.
    logic [31:0] m_data     [2][16];
    longint      m_ent      [2][16];
    int          m_head     [2];
    int          m_cnt      [2];
    bit          m_ovf      [2];
    bit          m_udf      [2];
    longint      m_last_deq [2];
    longint      cyc = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit m_emp(input int m);
        longint vis;
        if (m_cnt[m] == 0) return 1'b1;
        vis = m_ent[m][m_head[m]] + m + 1;
        if (m_last_deq[m] + 1 > vis) vis = m_last_deq[m] + 1;
        return (cyc < vis);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_head[m]     = 0;
            m_cnt[m]      = 0;
            m_ovf[m]      = 1'b0;
            m_udf[m]      = 1'b0;
            m_last_deq[m] = -100;
        end
    endtask

    task automatic model_step();
        bit e, deq_ok, enq_ok;
        int tail;
        for (int m = 0; m < 2; m++) begin
            if (clr) begin
                m_head[m]     = 0;
                m_cnt[m]      = 0;
                m_ovf[m]      = 1'b0;
                m_udf[m]      = 1'b0;
                m_last_deq[m] = -100;
            end else begin
                e      = m_emp(m);
                deq_ok = deq && !e;
                enq_ok = enq && ((m_cnt[m] < 16) || deq_ok);
                if (enq && !enq_ok) m_ovf[m] = 1'b1;
                if (deq && e)       m_udf[m] = 1'b1;
                tail = (m_head[m] + m_cnt[m]) % 16;
                if (deq_ok) begin
                    m_head[m]     = (m_head[m] + 1) % 16;
                    m_cnt[m]      = m_cnt[m] - 1;
                    m_last_deq[m] = cyc;
                end
                if (enq_ok) begin
                    m_data[m][tail] = din;
                    m_ent[m][tail]  = cyc;
                    m_cnt[m]        = m_cnt[m] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        bit e;
        for (int m = 0; m < 2; m++) begin
            e = m_emp(m);
            chk($sformatf("m%0d emp", m),   64'(emp[m]),   64'(e));
            chk($sformatf("m%0d dot", m),   64'(dot[m]),   e ? 64'd0 : 64'(m_data[m][m_head[m]]));
            chk($sformatf("m%0d cnt", m),   64'(cnt[m]),   64'(m_cnt[m]));
            chk($sformatf("m%0d full", m),  64'(full[m]),  64'(m_cnt[m] == 16));
            chk($sformatf("m%0d afull", m), 64'(afull[m]), 64'(m_cnt[m] >= 12));
            chk($sformatf("m%0d aemp", m),  64'(aemp[m]),  64'(m_cnt[m] <= 2));
            chk($sformatf("m%0d ovf", m),   64'(ovf[m]),   64'(m_ovf[m]));
            chk($sformatf("m%0d udf", m),   64'(udf[m]),   64'(m_udf[m]));
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model on the edge.
    task automatic step(input bit e, input bit d, input bit c, input logic [31:0] data);
        enq = e;
        deq = d;
        clr = c;
        din = data;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    initial begin
        int pe;
        int pd;
        rst_x = 1'b0;
        clr   = 1'b0;
        enq   = 1'b0;
        deq   = 1'b0;
        din   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_x = 1'b1;

        // Single word latency
        step(1, 0, 0, 32'h11);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Fill past full, then drain past empty
        for (int i = 1; i <= 17; i++) step(1, 0, 0, 32'(i));
        repeat (2) step(0, 0, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Full FIFO with simultaneous enq and deq
        step(0, 0, 1, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 32'h100 + 32'(i));
        repeat (2) step(0, 0, 0, 0);
        step(1, 1, 0, 32'hAA);
        for (int i = 0; i < 18; i++) step(0, 1, 0, 0);

        // Streaming enq+deq every cycle
        step(0, 0, 1, 0);
        for (int k = 0; k < 100; k++) step(1, 1, 0, 32'(2 * k + 1));
        repeat (4) step(0, 1, 0, 0);

        // Underflow, then flush with enq in the same cycle
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(1, 0, 1, 32'h77);
        repeat (3) step(0, 0, 0, 0);

        // Async reset mid-stream with 7 words held
        for (int i = 0; i < 7; i++) step(1, 0, 0, 32'h200 + 32'(i));
        enq = 1'b0;
        #3;
        rst_x = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #2;
        rst_x = 1'b1;
        step(1, 0, 0, 32'h5);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Random traffic in phases of varying enq/deq pressure
        for (int p = 0; p < 20; p++) begin
            pe = int'($urandom_range(90, 10));
            pd = int'($urandom_range(90, 10));
            for (int k = 0; k < 100; k++) begin
                step(int'($urandom_range(99, 0)) < pe,
                     int'($urandom_range(99, 0)) < pd,
                     $urandom_range(79, 0) == 0,
                     $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
